// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32IM execute stage: ALU controls, branch and M-extension
// funct3 codes, and the multiply/divide FSM states.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_cond_t;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  localparam int unsigned FWD_RD     = 0;
  localparam int unsigned FWD_RESULT = 1;
  localparam int unsigned FWD_ALUM   = 2;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU for the RV32I register/immediate operations.
module alu
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            op,
  output logic [DATA_WIDTH-1:0] y
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    y = '0;
    case (alu_op_t'(op))
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_SLT:   y = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  y = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:   y = a << shamt;
      ALU_SRL:   y = a >> shamt;
      ALU_SRA:   y = $signed(a) >>> shamt;
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative M-extension unit: one-step multiply, restoring divide at one quotient bit
// per cycle, operands captured once at issue.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  md_state_t      state;
  muldiv_op_t     op_q;
  logic [W-1:0]   a_q, b_q, rem_q, quo_q;
  logic [CW-1:0]  cnt;

  logic           in_signed, div0, ovf;
  logic [W-1:0]   a_mag;
  assign in_signed = ~op[0];
  assign div0      = (src_b == '0);
  assign ovf       = in_signed && (src_a == {1'b1, {(W-1){1'b0}}}) && (src_b == '1);
  assign a_mag     = (in_signed && src_a[W-1]) ? -src_a : src_a;

  logic           a_sgn, b_sgn;
  logic [2*W-1:0] a_ext, b_ext, product;
  assign a_sgn   = (op_q == MD_MULH) || (op_q == MD_MULHSU);
  assign b_sgn   = (op_q == MD_MULH);
  assign a_ext   = {{W{a_sgn & a_q[W-1]}}, a_q};
  assign b_ext   = {{W{b_sgn & b_q[W-1]}}, b_q};
  assign product = a_ext * b_ext;

  // Divide step: shift the next dividend bit into the partial remainder and subtract
  logic           d_signed, ge, q_neg, r_neg;
  logic [W-1:0]   dvsr, rem_n, quo_n, q_fin, r_fin;
  logic [W:0]     shifted, trial;
  assign d_signed = ~op_q[0];
  assign dvsr     = (d_signed && b_q[W-1]) ? -b_q : b_q;
  assign shifted  = {rem_q, quo_q[W-1]};
  assign trial    = shifted - {1'b0, dvsr};
  assign ge       = ~trial[W];
  assign rem_n    = ge ? trial[W-1:0] : shifted[W-1:0];
  assign quo_n    = {quo_q[W-2:0], ge};
  assign q_neg    = d_signed && (a_q[W-1] ^ b_q[W-1]);
  assign r_neg    = d_signed && a_q[W-1];
  assign q_fin    = q_neg ? -quo_n : quo_n;
  assign r_fin    = r_neg ? -rem_n : rem_n;

  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= MD_MUL;
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= src_a;
            b_q   <= src_b;
            op_q  <= muldiv_op_t'(op);
            rem_q <= '0;
            quo_q <= a_mag;
            cnt   <= CW'(W-1);
            if (!op[2]) begin
              state <= ST_MUL;
            end else if (div0) begin
              result <= op[1] ? src_a : '1;
              state  <= ST_DONE;
            end else if (ovf) begin
              result <= op[1] ? '0 : src_a;
              state  <= ST_DONE;
            end else begin
              state <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          result <= (op_q == MD_MUL) ? product[W-1:0] : product[2*W-1:W];
          state  <= ST_DONE;
        end
        ST_DIV: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          if (cnt == '0) begin
            result <= op_q[1] ? r_fin : q_fin;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mux.sv
// Generic N-input select; any select value at or beyond N yields zero.
module mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SW    = $clog2(N)
) (
  input  logic [N-1:0][WIDTH-1:0] data,
  input  logic [SW-1:0]           sel,
  output logic [WIDTH-1:0]        y
);

  always_comb begin
    y = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == SW'(i)) y = data[i];
    end
  end

endmodule

// File: rtl/execute_muldiv.sv
// Execute stage: forwarding muxes, ALU, branch resolution and the iterative
// multiply/divide unit that stalls the pipeline through BusyE.
module execute_muldiv
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_FWD    = 4,
  parameter int unsigned FW         = $clog2(NUM_FWD)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  FlushE,
  input  logic                  JumpE,
  input  logic                  BranchE,
  input  logic [2:0]            BranchCondE,
  input  logic [3:0]            ALUControlE,
  input  logic                  AluSrcE,
  input  logic                  MulDivE,
  input  logic [2:0]            MulDivOpE,
  input  logic [DATA_WIDTH-1:0] RD1E,
  input  logic [DATA_WIDTH-1:0] RD2E,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic [DATA_WIDTH-1:0] ExtImmE,
  input  logic [FW-1:0]         ForwardAE,
  input  logic [FW-1:0]         ForwardBE,
  input  logic [DATA_WIDTH-1:0] ResultW,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  output logic                  PCSrcE,
  output logic [DATA_WIDTH-1:0] PCTargetE,
  output logic [DATA_WIDTH-1:0] ALUResultE,
  output logic [DATA_WIDTH-1:0] WriteDataE,
  output logic                  BusyE
);

  logic [NUM_FWD-1:0][DATA_WIDTH-1:0] fwd_a, fwd_b;
  logic [DATA_WIDTH-1:0] src_a, src_b, alu_y, md_result;
  logic                  md_done, cond;

  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    fwd_a[FWD_RD]     = RD1E;
    fwd_b[FWD_RD]     = RD2E;
    fwd_a[FWD_RESULT] = ResultW;
    fwd_b[FWD_RESULT] = ResultW;
    fwd_a[FWD_ALUM]   = ALUResultM;
    fwd_b[FWD_ALUM]   = ALUResultM;
  end

  mux #(.WIDTH(DATA_WIDTH), .N(NUM_FWD), .SW(FW)) u_fwd_a (
    .data(fwd_a), .sel(ForwardAE), .y(src_a)
  );

  mux #(.WIDTH(DATA_WIDTH), .N(NUM_FWD), .SW(FW)) u_fwd_b (
    .data(fwd_b), .sel(ForwardBE), .y(WriteDataE)
  );

  assign src_b = AluSrcE ? ExtImmE : WriteDataE;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a(src_a), .b(src_b), .op(ALUControlE), .y(alu_y)
  );

  always_comb begin
    cond = 1'b0;
    case (br_cond_t'(BranchCondE))
      BR_EQ:   cond = (src_a == src_b);
      BR_NE:   cond = (src_a != src_b);
      BR_LT:   cond = ($signed(src_a) < $signed(src_b));
      BR_GE:   cond = ($signed(src_a) >= $signed(src_b));
      BR_LTU:  cond = (src_a < src_b);
      BR_GEU:  cond = (src_a >= src_b);
      default: cond = 1'b0;
    endcase
  end

  assign PCSrcE    = ~FlushE & (JumpE | (BranchE & cond));
  assign PCTargetE = PCE + ExtImmE;

  muldiv_unit #(.DATA_WIDTH(DATA_WIDTH)) u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (FlushE),
    .start  (MulDivE),
    .op     (MulDivOpE),
    .src_a  (src_a),
    .src_b  (src_b),
    .done   (md_done),
    .result (md_result)
  );

  // Combinational so the hazard unit sees the stall in the issue cycle
  assign BusyE      = MulDivE & ~FlushE & ~md_done;
  assign ALUResultE = md_done ? md_result : alu_y;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed-vector bench for execute_muldiv with hand-computed expected values.
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        FlushE, JumpE, BranchE, AluSrcE, MulDivE;
  logic [2:0]  BranchCondE, MulDivOpE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, ExtImmE, ResultW, ALUResultM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        PCSrcE, BusyE;
  logic [31:0] PCTargetE, ALUResultE, WriteDataE;

  int unsigned checks = 0;
  int unsigned errors = 0;

  execute_muldiv #(.DATA_WIDTH(32), .NUM_FWD(4)) dut (
    .clk(clk), .rst_n(rst_n), .FlushE(FlushE), .JumpE(JumpE), .BranchE(BranchE),
    .BranchCondE(BranchCondE), .ALUControlE(ALUControlE), .AluSrcE(AluSrcE),
    .MulDivE(MulDivE), .MulDivOpE(MulDivOpE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
    .ExtImmE(ExtImmE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .ALUResultM(ALUResultM), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .BusyE(BusyE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one M op at the current IDLE cycle; scrambles all operand sources after
  // issue, and returns one cycle after DONE so the next op issues with no gap.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] fa,
                        input logic [31:0] exp, input int unsigned exp_busy);
    int unsigned n;
    MulDivE = 1'b1; MulDivOpE = op; AluSrcE = 1'b0;
    RD1E = a; ResultW = a; ALUResultM = a; RD2E = b;
    ForwardAE = fa; ForwardBE = 2'd0;
    #1;
    n = 0;
    while (BusyE && n < 100) begin
      @(posedge clk); #1;
      n++;
      RD1E = $urandom; RD2E = $urandom; ResultW = $urandom; ALUResultM = $urandom;
      #1;
    end
    check({tag, "_busy"}, n, exp_busy);
    check({tag, "_res"}, ALUResultE, exp);
    check({tag, "_pcsrc"}, {31'd0, PCSrcE}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; FlushE = 0; JumpE = 0; BranchE = 0; AluSrcE = 0; MulDivE = 0;
    BranchCondE = 3'd0; MulDivOpE = 3'd0; ALUControlE = 4'd0;
    RD1E = 0; RD2E = 0; PCE = 0; ExtImmE = 0; ResultW = 0; ALUResultM = 0;
    ForwardAE = 0; ForwardBE = 0;
    #2;
    check("rst_busy", {31'd0, BusyE}, 32'd0);
    check("rst_pcsrc", {31'd0, PCSrcE}, 32'd0);
    check("rst_state", 32'(dut.u_md.state), 32'd0);
    check("rst_result", dut.u_md.result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Forwarding
    RD1E = 32'd5; ALUResultM = 32'd9; ResultW = 32'd20; ForwardAE = 2'd2;
    AluSrcE = 1'b1; ExtImmE = 32'd1; ALUControlE = 4'd0;
    #1 check("fwd_alum", ALUResultE, 32'd10);
    ForwardAE = 2'd3;
    #1 check("fwd_zero", ALUResultE, 32'd1);
    ForwardAE = 2'd1;
    #1 check("fwd_resw", ALUResultE, 32'd21);
    ForwardAE = 2'd0; AluSrcE = 1'b0; RD2E = 32'd7; ALUControlE = 4'd1;
    #1 check("sub_rd", ALUResultE, 32'hFFFF_FFFE);
    check("wdata_rd", WriteDataE, 32'd7);
    ForwardBE = 2'd2;
    #1 check("wdata_alum", WriteDataE, 32'd9);
    ForwardBE = 2'd0;

    // Branches
    RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; BranchE = 1'b1;
    BranchCondE = 3'b100; #1 check("blt", {31'd0, PCSrcE}, 32'd1);
    BranchCondE = 3'b110; #1 check("bltu", {31'd0, PCSrcE}, 32'd0);
    BranchCondE = 3'b101; #1 check("bge", {31'd0, PCSrcE}, 32'd0);
    BranchCondE = 3'b111; #1 check("bgeu", {31'd0, PCSrcE}, 32'd1);
    BranchCondE = 3'b000; #1 check("beq", {31'd0, PCSrcE}, 32'd0);
    BranchCondE = 3'b001; #1 check("bne", {31'd0, PCSrcE}, 32'd1);
    FlushE = 1'b1;        #1 check("bne_flush", {31'd0, PCSrcE}, 32'd0);
    FlushE = 1'b0; BranchE = 1'b0; JumpE = 1'b1;
    #1 check("jump", {31'd0, PCSrcE}, 32'd1);
    JumpE = 1'b0; PCE = 32'h100; ExtImmE = 32'hFFFF_FFF8;
    #1 check("pctarget", PCTargetE, 32'h0000_00F8);
    check("nobr_pcsrc", {31'd0, PCSrcE}, 32'd0);
    ALUControlE = 4'd0;
    @(posedge clk); #1;

    // Multiply / divide, back to back
    run_md("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 2'd0, 32'h4000_0000, 2);
    run_md("mulhu",  3'b011, 32'hFFFF_FFFF, 32'd2,         2'd0, 32'd1,         2);
    run_md("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         2'd0, 32'hFFFF_FFFF, 2);
    run_md("mul",    3'b000, 32'hFFFF_FFFD, 32'd4,         2'd0, 32'hFFFF_FFF4, 2);
    run_md("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         2'd1, 32'hFFFF_FFFD, 33);
    run_md("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         2'd1, 32'hFFFF_FFFF, 33);
    run_md("div_nn", 3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 2'd0, 32'd3,         33);
    run_md("rem_pn", 3'b110, 32'd7,         32'hFFFF_FFFE, 2'd2, 32'd1,         33);
    run_md("divu",   3'b101, 32'd100,       32'd7,         2'd0, 32'd14,        33);
    run_md("remu",   3'b111, 32'd100,       32'd7,         2'd0, 32'd2,         33);
    run_md("div0",   3'b100, 32'h0000_1234, 32'd0,         2'd0, 32'hFFFF_FFFF, 1);
    run_md("rem0",   3'b110, 32'h0000_1234, 32'd0,         2'd0, 32'h0000_1234, 1);
    run_md("divu0",  3'b101, 32'd55,        32'd0,         2'd0, 32'hFFFF_FFFF, 1);
    run_md("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 2'd0, 32'h8000_0000, 1);
    run_md("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 2'd0, 32'd0,         1);
    MulDivE = 1'b0;
    @(posedge clk); #1;

    // Flush during the tenth divide iteration
    MulDivE = 1'b1; MulDivOpE = 3'b100; ForwardAE = 2'd0; RD1E = 32'd1000; RD2E = 32'd3;
    for (int k = 0; k < 10; k++) begin @(posedge clk); #1; end
    check("pre_flush_busy", {31'd0, BusyE}, 32'd1);
    FlushE = 1'b1;
    #1 check("flush_busy", {31'd0, BusyE}, 32'd0);
    @(posedge clk); #1;
    FlushE = 1'b0; MulDivE = 1'b0;
    #1 check("flush_state", 32'(dut.u_md.state), 32'd0);
    check("flush_busy_after", {31'd0, BusyE}, 32'd0);
    run_md("mul_after_flush", 3'b000, 32'd3, 32'd4, 2'd0, 32'd12, 2);

    // Asynchronous reset mid-divide
    MulDivE = 1'b1; MulDivOpE = 3'b101; ForwardAE = 2'd0; RD1E = 32'd100; RD2E = 32'd7;
    for (int k = 0; k < 5; k++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1 check("arst_state", 32'(dut.u_md.state), 32'd0);
    check("arst_result", dut.u_md.result, 32'd0);
    check("arst_cnt", 32'(dut.u_md.cnt), 32'd0);
    MulDivE = 1'b0;
    #1 check("arst_busy", {31'd0, BusyE}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_md("mul_after_rst", 3'b000, 32'd6, 32'd7, 2'd0, 32'd42, 2);
    MulDivE = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_muldiv.md
# execute_muldiv

Parametrised execute stage for the pipelined RV32IM core, the successor to the single-cycle execute stage. It keeps forwarding muxes and an ALU, generalises the forwarding-source count and branch resolution to all six RV32I conditions, and adds an iterative M-extension multiply/divide unit. The unit holds the pipeline through a `BusyE` stall request to the hazard unit. It sits between the ID/EX and EX/MEM pipeline registers.

## Interface
- `DATA_WIDTH`, 32, operand and result width; must be even and ≥ 8
- `NUM_FWD`, 4, forwarding sources per operand mux; select width is `FW = $clog2(NUM_FWD)`
- `clk` in 1: core clock
- `rst_n` in 1: reset; one clock, asynchronous, active-low
- `FlushE` in 1: kill the instruction in E and abort any multiply/divide in flight
- `JumpE`, `BranchE` in 1: jump / conditional branch
- `BranchCondE` in 3: funct3 for BEQ, BNE, BLT, BGE, BLTU, BGEU
- `ALUControlE` in 4: ALU operation
- `AluSrcE` in 1: SrcB select; 1 selects `ExtImmE`
- `MulDivE` in 1: instruction is an M-extension op
- `MulDivOpE` in 3: funct3 for MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- `RD1E`, `RD2E`, `PCE`, `ExtImmE` in DATA_WIDTH: register operands, PC, immediate
- `ForwardAE`, `ForwardBE` in FW: forwarding selects
- `ResultW`, `ALUResultM` in DATA_WIDTH: forwarding sources
- `PCSrcE` out 1: redirect fetch
- `PCTargetE` out DATA_WIDTH: `PCE + ExtImmE`, wrapping modulo 2^DATA_WIDTH
- `ALUResultE`, `WriteDataE` out DATA_WIDTH: result, forwarded store data
- `BusyE` out 1: stall request; hold F/D/E and bubble M

## Operation
- Forwarding select values:
  - 0 selects `RD1E`/`RD2E`
  - 1 selects `ResultW`
  - 2 selects `ALUResultM`
  - ≥3 selects zero
  - `WriteDataE` is the B-mux output.
- Branches are resolved on `SrcAE`/`SrcBE` compares, not on the ALU zero flag. `PCSrcE = JumpE | (BranchE & cond)`.
- `PCSrcE` is suppressed while `FlushE` is high.
- Non-M ops are purely combinational and have zero latency.
- MUL FSM:
  - States are IDLE, MUL, DIV, DONE. Reset and flush state is IDLE.
  - IDLE with `MulDivE=1` and `FlushE=0`: latch SrcA, SrcB and op, then go to MUL (multiply ops) or DIV (divide ops).
  - Divide by zero or signed overflow (`-2^(W-1) / -1`) goes directly from IDLE to DONE.
  - MUL: compute the 2W-bit product of the sign/zero-extended operands and register the selected half, then go to DONE.
  - DIV: restoring divide of magnitudes, one quotient bit per cycle for DATA_WIDTH cycles. An iteration counter counts down to 0; at 0, apply result sign and go to DONE.
  - DONE: go to IDLE unconditionally. Doing so prevents a re-start by the still-resident instruction.
- `BusyE = MulDivE & ~FlushE & (state != DONE)`. The expression is combinational, so a stall takes effect in the issue cycle.
- `ALUResultE` is the muldiv result register in DONE and the ALU output otherwise.
- Operands are captured once in IDLE. Forwarding sources may change during the stall and must not affect the result.
- Special results:
  - Divide by zero: quotient all-ones, remainder equals the dividend.
  - Overflow: quotient `-2^(W-1)`, remainder 0.
  - Remainder sign follows the dividend.
- `FlushE` in any state forces IDLE on the next edge and discards the result.
- `rst_n` low mid-operation clears state, counter and result register asynchronously.

## Timing
- Reset values:
  - state IDLE, counter 0, result register 0
  - `BusyE` 0 with `MulDivE` low
  - `PCSrcE` 0 with `JumpE`/`BranchE` low
  - all other outputs combinational from inputs
- MUL occupies E for 3 cycles (IDLE, MUL, DONE); `BusyE` is high for 2 of them.
- DIV/REM occupies E for DATA_WIDTH+2 cycles (34 at default). Divide by zero and overflow occupy 2 cycles.
- Back-to-back M ops: the second starts in the IDLE cycle immediately after DONE, with no dead cycle.
- `PCSrcE` and `PCTargetE` are valid in the same cycle as the branch, and in the DONE cycle for an M op (always 0 then).

## Structure
- `riscv_pkg`:
  - `alu_op_t` (4-bit ALU controls)
  - `br_cond_t` (funct3 branch codes)
  - `muldiv_op_t` (funct3 M codes)
  - `md_state_t`
- Sub-module `muldiv_unit`: FSM, operand latches, multiplier, divider and counter.
- The top level keeps the forwarding muxes (reusing `mux`), `alu` and branch compare.

## Test plan
- Forwarding: `RD1E=5`, `ALUResultM=9`, `ForwardAE=2`, ADD with imm 1 → `ALUResultE=10`. `ForwardAE=3` → SrcA=0.
- Branches: `SrcA=0xFFFFFFFF`, `SrcB=1`, BLT → `PCSrcE=1`; BLTU → `PCSrcE=0`. `PCE=0x100`, `ExtImmE=-8` → `PCTargetE=0xF8`.
- MULH `0x80000000 × 0x80000000` → `BusyE` high 2 cycles, then `0x40000000`. MULHU `0xFFFFFFFF × 2` → `1`.
- DIV `-7 / 2` → after 34 cycles quotient `-3`; REM → `-1`. Change `ResultW` mid-stall → result unchanged.
- DIV `x / 0` → `0xFFFFFFFF` after 2 cycles, REM → `x`. DIV `0x80000000 / -1` → `0x80000000`, REM → 0.
- Assert `FlushE` at DIV iteration 10 → IDLE next cycle, `BusyE` low. A following MUL `3×4` returns `12`. Pulse `rst_n` low mid-DIV → state IDLE and result 0 immediately.
